// File: rtl/riscv_pkg.sv
// Shared types and default sizing for the multi-ported register file.
package riscv_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NWR_DEF   = 2;

endpackage

// File: rtl/riscv_regfile_wsel.sv
// Write-port priority select for one register address: reports whether any
// enabled port targets a writable entry and which data wins (highest port).
module riscv_regfile_wsel #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NWR   = 2,
    parameter int AW    = 5
) (
    input  logic [AW-1:0]            addr_i,
    input  logic [NWR-1:0]           w_en_i,
    input  logic [NWR-1:0][AW-1:0]   w_addr_i,
    input  logic [NWR-1:0][XLEN-1:0] w_data_i,
    output logic                     hit_o,
    output logic [XLEN-1:0]          data_o
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic addr_ok;

    always_comb begin
        hit_o   = 1'b0;
        data_o  = '0;
        addr_ok = (addr_i != '0) && ({1'b0, addr_i} < NREGS_W);
        // Ascending scan so the last (highest-index) matching port wins.
        for (int k = 0; k < NWR; k++) begin
            if (addr_ok && w_en_i[k] && (w_addr_i[k] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = w_data_i[k];
            end
        end
    end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-ported register file with zero-cycle write bypass, per-entry pending
// (scoreboard) bits and a post-reset zeroing sweep before it reports ready.
module riscv_regfile_mp
    import riscv_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    parameter int  NRD   = NRD_DEF,
    parameter int  NWR   = NWR_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0][AW-1:0]   r_addr,
    output logic [NRD-1:0][XLEN-1:0] rd_data,
    output logic [NRD-1:0]           busy,
    input  logic [NWR-1:0]           w_en,
    input  logic [NWR-1:0][AW-1:0]   w_addr,
    input  logic [NWR-1:0][XLEN-1:0] w_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic                     ready
);

    localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

    state_e                       state_q, state_d;
    logic [AW-1:0]                cnt_q, cnt_d;
    logic [NREGS-1:0][XLEN-1:0]   mem_q, mem_d;
    logic [NREGS-1:0]             pend_q, pend_d;

    logic                         run;
    logic [NWR-1:0]               w_en_run;
    logic                         rsv_ok;
    logic [NREGS-1:0]             ent_hit;
    logic [NREGS-1:0][XLEN-1:0]   ent_data;

    assign run      = (state_q == RUN);
    assign ready    = run;
    assign w_en_run = w_en & {NWR{run}};
    assign rsv_ok   = run && rsv_en && (rsv_addr != '0) && ({1'b0, rsv_addr} < NREGS_W);

    for (genvar e = 0; e < NREGS; e++) begin : g_ent
        riscv_regfile_wsel #(
            .XLEN (XLEN),
            .NREGS(NREGS),
            .NWR  (NWR),
            .AW   (AW)
        ) u_wsel (
            .addr_i  (AW'(e)),
            .w_en_i  (w_en_run),
            .w_addr_i(w_addr),
            .w_data_i(w_data),
            .hit_o   (ent_hit[e]),
            .data_o  (ent_data[e])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        pend_d  = pend_q;
        if (!run) begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            for (int e = 0; e < NREGS; e++) begin
                if (ent_hit[e]) begin
                    mem_d[e]  = ent_data[e];
                    pend_d[e] = 1'b0;
                end
            end
            // Applied after the write clear so a same-cycle reservation sticks.
            if (rsv_ok) pend_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Storage carries no reset; the sweep defines it before ready rises.
    always_ff @(posedge clk) begin
        if (rst_n) mem_q <= mem_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic            rd_ok;
        logic            byp_hit;
        logic [XLEN-1:0] byp_data;

        riscv_regfile_wsel #(
            .XLEN (XLEN),
            .NREGS(NREGS),
            .NWR  (NWR),
            .AW   (AW)
        ) u_byp (
            .addr_i  (r_addr[i]),
            .w_en_i  (w_en_run),
            .w_addr_i(w_addr),
            .w_data_i(w_data),
            .hit_o   (byp_hit),
            .data_o  (byp_data)
        );

        assign rd_ok      = run && (r_addr[i] != '0) && ({1'b0, r_addr[i]} < NREGS_W);
        assign rd_data[i] = rd_ok ? (byp_hit ? byp_data : mem_q[r_addr[i]]) : '0;
        assign busy[i]    = rd_ok && pend_q[r_addr[i]] && !byp_hit;
    end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Bench for riscv_regfile_mp: default instance checked every cycle against a
// behavioural model, plus a directed check of a 24-entry / 3R / 1W instance.
module tb_riscv_regfile_mp;

    localparam int XL = 32;
    localparam int N  = 32;
    localparam int RD = 2;
    localparam int WR = 2;
    localparam int AW = 5;

    localparam int N2  = 24;
    localparam int RD2 = 3;
    localparam int WR2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [RD-1:0][AW-1:0]   r_addr;
    logic [RD-1:0][XL-1:0]   rd_data;
    logic [RD-1:0]           busy;
    logic [WR-1:0]           w_en;
    logic [WR-1:0][AW-1:0]   w_addr;
    logic [WR-1:0][XL-1:0]   w_data;
    logic                    rsv_en;
    logic [AW-1:0]           rsv_addr;
    logic                    ready;

    logic                    b_rst_n;
    logic [RD2-1:0][AW-1:0]  b_r_addr;
    logic [RD2-1:0][XL-1:0]  b_rd_data;
    logic [RD2-1:0]          b_busy;
    logic [WR2-1:0]          b_w_en;
    logic [WR2-1:0][AW-1:0]  b_w_addr;
    logic [WR2-1:0][XL-1:0]  b_w_data;
    logic                    b_rsv_en;
    logic [AW-1:0]           b_rsv_addr;
    logic                    b_ready;

    riscv_regfile_mp #(.XLEN(XL), .NREGS(N), .NRD(RD), .NWR(WR)) dut (
        .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .rd_data(rd_data), .busy(busy),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ready(ready)
    );

    riscv_regfile_mp #(.XLEN(XL), .NREGS(N2), .NRD(RD2), .NWR(WR2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .r_addr(b_r_addr), .rd_data(b_rd_data), .busy(b_busy),
        .w_en(b_w_en), .w_addr(b_w_addr), .w_data(b_w_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .ready(b_ready)
    );

    int vecs = 0;
    int errs = 0;

    // Reference model of the default instance.
    logic [XL-1:0] m_mem [N];
    bit            m_pend[N];
    bit            m_ready = 1'b0;
    int            m_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vecs++;
        assert (obs === exp_v)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_read(input int a, output logic [XL-1:0] d, output logic b);
        bit hit = 1'b0;
        d = '0;
        b = 1'b0;
        if (m_ready && a != 0 && a < N) begin
            for (int k = WR - 1; k >= 0; k--) begin
                if (!hit && w_en[k] && int'(w_addr[k]) == a) begin
                    hit = 1'b1;
                    d   = w_data[k];
                end
            end
            if (!hit) d = m_mem[a];
            b = m_pend[a] && !hit;
        end
    endtask

    // Check combinational outputs, clock once, advance the model.
    task automatic cyc(input string tag);
        logic [XL-1:0] e;
        logic          eb;
        #1;
        for (int i = 0; i < RD; i++) begin
            exp_read(int'(r_addr[i]), e, eb);
            chk($sformatf("%s/rd%0d@%0d", tag, i, r_addr[i]), 64'(rd_data[i]), 64'(e));
            chk($sformatf("%s/busy%0d@%0d", tag, i, r_addr[i]), 64'(busy[i]), 64'(eb));
        end
        chk({tag, "/ready"}, 64'(ready), 64'(m_ready));
        @(posedge clk);
        if (!rst_n) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            for (int a = 0; a < N; a++) begin
                m_pend[a] = 1'b0;
                m_mem[a]  = '0;
            end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == N) m_ready = 1'b1;
        end else begin
            for (int k = 0; k < WR; k++) begin
                if (w_en[k] && w_addr[k] != 0) begin
                    m_mem[w_addr[k]]  = w_data[k];
                    m_pend[w_addr[k]] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        w_en   = '0;
        w_addr = '0;
        w_data = '0;
        rsv_en = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < WR; k++) begin
            w_en[k]   = 1'($urandom_range(0, 1));
            w_addr[k] = AW'($urandom_range(0, 15));
            w_data[k] = $urandom;
        end
        if ($urandom_range(0, 3) == 0) w_addr[1] = w_addr[0];
        rsv_en   = ($urandom_range(0, 3) == 0);
        rsv_addr = AW'($urandom_range(0, 15));
        for (int i = 0; i < RD; i++) r_addr[i] = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) r_addr[0] = w_addr[1];
    endtask

    initial begin
        rst_n = 1'b0;
        r_addr = '0;
        idle();
        b_rst_n = 1'b0;
        b_r_addr = '0;
        b_w_en = '0;
        b_w_addr = '0;
        b_w_data = '0;
        b_rsv_en = 1'b0;
        b_rsv_addr = '0;
        for (int a = 0; a < N; a++) begin
            m_mem[a]  = '0;
            m_pend[a] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);

        // Reset held for two cycles, then a sweep with ignored random traffic.
        cyc("rst");
        cyc("rst");
        rst_n = 1'b1;
        for (int c = 0; c < 34; c++) begin
            randomize_inputs();
            cyc($sformatf("sweep%0d", c));
        end
        idle();
        for (int a = 0; a < N; a++) begin
            r_addr[0] = AW'(a);
            r_addr[1] = AW'(N - 1 - a);
            cyc("zero");
        end

        // Write with same-cycle bypass, then persistence.
        w_en[0] = 1'b1; w_addr[0] = 5; w_data[0] = 32'hCAFEF0DA; r_addr[0] = 5;
        cyc("byp");
        idle();
        for (int c = 0; c < 3; c++) cyc("byp_hold");

        // Port conflict on 7 and write to entry 0.
        w_en = 2'b11; w_addr[0] = 7; w_addr[1] = 7;
        w_data[0] = 32'h11111111; w_data[1] = 32'h22222222; r_addr[0] = 7;
        cyc("conf");
        w_en = 2'b01; w_addr[0] = 0; w_data[0] = 32'hFFFFFFFF; r_addr[1] = 0;
        cyc("zero_wr");
        idle();
        cyc("conf_hold");

        // Scoreboard on entry 9.
        r_addr[0] = 9;
        rsv_en = 1'b1; rsv_addr = 9;
        cyc("rsv");
        idle();
        cyc("rsv_busy");
        w_en[0] = 1'b1; w_addr[0] = 9; w_data[0] = 32'h1004;
        cyc("rsv_clr");
        rsv_en = 1'b1; rsv_addr = 9; w_data[0] = 32'h2008;
        cyc("rsv_wr");
        idle();
        cyc("rsv_win");

        for (int c = 0; c < 300; c++) begin
            randomize_inputs();
            cyc("rand");
        end
        idle();

        // Mid-operation reset, re-asserted at sweep cycle 10.
        w_en[0] = 1'b1; w_addr[0] = 3; w_data[0] = 32'hDEADB0DE;
        rsv_en = 1'b1; rsv_addr = 4;
        cyc("pre_rst");
        idle();
        rst_n = 1'b0;
        cyc("mrst");
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) cyc("msweep");
        rst_n = 1'b0;
        cyc("mrst2");
        rst_n = 1'b1;
        r_addr[0] = 3; r_addr[1] = 4;
        for (int c = 0; c < 34; c++) cyc("msweep2");

        // Second instance: 24 entries, 3 read ports, 1 write port.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int c = 0; c < 26; c++) begin
            #1;
            chk($sformatf("b/ready%0d", c), 64'(b_ready), 64'(c >= N2));
            @(negedge clk);
        end
        b_w_en = 1'b1; b_w_addr[0] = 30; b_w_data[0] = 32'h12345678;
        b_rsv_en = 1'b1; b_rsv_addr = 30;
        b_r_addr[0] = 30; b_r_addr[1] = 23; b_r_addr[2] = 24;
        #1;
        chk("b/oob_rd", 64'(b_rd_data[0]), 64'd0);
        chk("b/oob_busy", 64'(b_busy[0]), 64'd0);
        @(negedge clk);
        b_w_en = 1'b0; b_rsv_en = 1'b0;
        #1;
        chk("b/oob_rd2", 64'(b_rd_data[0]), 64'd0);
        chk("b/oob_busy2", 64'(b_busy[0]), 64'd0);
        chk("b/rd23", 64'(b_rd_data[1]), 64'd0);
        @(negedge clk);
        b_w_en = 1'b1; b_w_addr[0] = 23; b_w_data[0] = 32'hABCD0123;
        #1;
        chk("b/byp23", 64'(b_rd_data[1]), 64'hABCD0123);
        @(negedge clk);
        b_w_en = 1'b0; b_rsv_en = 1'b1; b_rsv_addr = 23;
        #1;
        chk("b/hold23", 64'(b_rd_data[1]), 64'hABCD0123);
        chk("b/rd24", 64'(b_rd_data[2]), 64'd0);
        @(negedge clk);
        b_rsv_en = 1'b0;
        #1;
        chk("b/busy23", 64'(b_busy[1]), 64'd1);
        chk("b/busy24", 64'(b_busy[2]), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
